// File: rtl/lbp_hist.sv
// LBP code histogram: counts each of the 256 codes over one frame, then
// streams the bins out with a valid/ready handshake, clearing each bin as it
// is accepted so the next frame starts from an empty histogram.
module lbp_hist #(
    parameter int COUNT_W = 14,
    parameter int IMG_W   = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               lbp_valid,
    input  logic [7:0]         lbp_data,
    input  logic [13:0]        lbp_addr,
    input  logic               finish,
    input  logic               hist_ready,
    output logic               hist_valid,
    output logic [7:0]         hist_bin,
    output logic [COUNT_W-1:0] hist_count,
    output logic               hist_done,
    output logic [COUNT_W-1:0] pix_total,
    output logic               err
);

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_DUMP  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    // Border geometry: first/last column, first row, last row of the frame.
    localparam logic [6:0]  COL_LAST       = 7'(IMG_W - 1);
    localparam logic [13:0] FIRST_ROW_END  = 14'(IMG_W);
    localparam logic [13:0] LAST_ROW_START = 14'(IMG_W * (IMG_W - 1));

    logic [1:0]         state_q, state_d;
    logic [7:0]         idx_q, idx_d;
    logic [COUNT_W-1:0] pix_total_q, pix_total_d;
    logic               err_q, err_d;
    logic [COUNT_W-1:0] bins_q [256];

    logic               binWe;
    logic [7:0]         binWaddr;
    logic [COUNT_W-1:0] binWdata;
    logic [COUNT_W-1:0] binCur;
    logic               binSat;
    logic               totalSat;
    logic               onBorder;

    assign binCur   = bins_q[lbp_data];
    assign binSat   = (binCur == CNT_MAX);
    assign totalSat = (pix_total_q == CNT_MAX);
    assign onBorder = (lbp_addr[6:0] == 7'd0) || (lbp_addr[6:0] == COL_LAST) ||
                      (lbp_addr < FIRST_ROW_END) || (lbp_addr >= LAST_ROW_START);

    // Next-state logic; the bin array gets at most one write per cycle, either
    // the accumulate increment or the clear-on-read during the dump.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pix_total_d = pix_total_q;
        err_d       = err_q;
        binWe       = 1'b0;
        binWaddr    = lbp_data;
        binWdata    = binCur;
        case (state_q)
            ST_ACCUM: begin
                if (lbp_valid) begin
                    binWe       = 1'b1;
                    binWaddr    = lbp_data;
                    binWdata    = binSat ? binCur : binCur + CNT_ONE;
                    pix_total_d = totalSat ? pix_total_q : pix_total_q + CNT_ONE;
                    if (binSat || totalSat || onBorder) begin
                        err_d = 1'b1;
                    end
                end
                if (finish) begin
                    state_d = ST_DUMP;
                    idx_d   = 8'd0;
                end
            end
            ST_DUMP: begin
                if (lbp_valid) begin
                    err_d = 1'b1;
                end
                if (hist_ready) begin
                    binWe    = 1'b1;
                    binWaddr = idx_q;
                    binWdata = '0;
                    idx_d    = idx_q + 8'd1;
                    if (idx_q == 8'd255) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (lbp_valid) begin
                    err_d = 1'b1;
                end
                pix_total_d = '0;
                idx_d       = 8'd0;
                state_d     = ST_ACCUM;
            end
            default: begin
                state_d = ST_ACCUM;
                idx_d   = 8'd0;
            end
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ACCUM;
            idx_q       <= 8'd0;
            pix_total_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pix_total_q <= pix_total_d;
            err_q       <= err_d;
        end
    end

    // Bin storage with a single read-modify-write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                bins_q[i] <= '0;
            end
        end else if (binWe) begin
            bins_q[binWaddr] <= binWdata;
        end
    end

    assign hist_valid = (state_q == ST_DUMP);
    assign hist_bin   = idx_q;
    assign hist_count = (state_q == ST_DUMP) ? bins_q[idx_q] : '0;
    assign hist_done  = (state_q == ST_DONE);
    assign pix_total  = pix_total_q;
    assign err        = err_q;

endmodule

// File: tb/tb_lbp_hist.sv
// Bench for lbp_hist: a behavioural histogram model checked every cycle,
// plus directed frames with hand-computed bin contents.
module tb_lbp_hist;

    localparam int COUNT_W = 14;
    localparam int CNT_MAX = (1 << COUNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               lbp_valid = 1'b0;
    logic [7:0]         lbp_data = 8'd0;
    logic [13:0]        lbp_addr = 14'd0;
    logic               finish = 1'b0;
    logic               hist_ready = 1'b0;
    logic               hist_valid;
    logic [7:0]         hist_bin;
    logic [COUNT_W-1:0] hist_count;
    logic               hist_done;
    logic [COUNT_W-1:0] pix_total;
    logic               err;

    int testsRun = 0;
    int testsFailed = 0;

    // Model state: 0 = accumulating, 1 = dumping, 2 = done cycle.
    int mBins[256];
    int mTotal = 0;
    int mErr = 0;
    int mMode = 0;
    int mIdx = 0;

    int dumpCnt[256];

    always #5 clk = ~clk;

    lbp_hist #(.COUNT_W(COUNT_W), .IMG_W(128)) dut (
        .clk(clk),
        .reset(reset),
        .lbp_valid(lbp_valid),
        .lbp_data(lbp_data),
        .lbp_addr(lbp_addr),
        .finish(finish),
        .hist_ready(hist_ready),
        .hist_valid(hist_valid),
        .hist_bin(hist_bin),
        .hist_count(hist_count),
        .hist_done(hist_done),
        .pix_total(pix_total),
        .err(err)
    );

    function automatic void checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endfunction

    function automatic bit isBorder(input int a);
        int row;
        int col;
        row = a / 128;
        col = a % 128;
        return (row == 0) || (row == 127) || (col == 0) || (col == 127);
    endfunction

    // Histogram model advanced on every clock from the sampled inputs.
    always @(posedge clk) begin
        if (reset) begin
            foreach (mBins[i]) mBins[i] = 0;
            mTotal = 0;
            mErr = 0;
            mMode = 0;
            mIdx = 0;
        end else if (mMode == 0) begin
            if (lbp_valid) begin
                if (mBins[int'(lbp_data)] == CNT_MAX || mTotal == CNT_MAX) mErr = 1;
                if (isBorder(int'(lbp_addr))) mErr = 1;
                if (mBins[int'(lbp_data)] < CNT_MAX) mBins[int'(lbp_data)] += 1;
                if (mTotal < CNT_MAX) mTotal += 1;
            end
            if (finish) begin
                mMode = 1;
                mIdx = 0;
            end
        end else if (mMode == 1) begin
            if (lbp_valid) mErr = 1;
            if (hist_ready) begin
                mBins[mIdx] = 0;
                if (mIdx == 255) mMode = 2;
                else mIdx += 1;
            end
        end else begin
            if (lbp_valid) mErr = 1;
            mTotal = 0;
            mMode = 0;
            mIdx = 0;
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("hist_valid", int'(hist_valid), int'(mMode == 1));
            checkOutput("hist_done", int'(hist_done), int'(mMode == 2));
            checkOutput("pix_total", int'(pix_total), mTotal);
            checkOutput("err", int'(err), mErr);
            if (mMode == 1) begin
                checkOutput("hist_bin", int'(hist_bin), mIdx);
                checkOutput("hist_count", int'(hist_count), mBins[mIdx]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit v, input int d, input int a, input bit f);
        lbp_valid = v;
        lbp_data = 8'(d);
        lbp_addr = 14'(a);
        finish = f;
        tick();
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Drives one dump after the finish cycle; optional abort or injected sample.
    task automatic doDump(input bit randomReady, input int abortAt, input int injectAt);
        int expBin = 0;
        int cycles = 0;
        int lastAccept = -10;
        int doneCycle = -1;
        int inject = injectAt;
        foreach (dumpCnt[i]) dumpCnt[i] = 0;
        lbp_valid = 1'b0;
        finish = 1'b0;
        while (doneCycle < 0 && cycles < 3000) begin
            hist_ready = randomReady ? ($urandom_range(0, 1) == 1) : 1'b1;
            lbp_valid = 1'b0;
            if (abortAt >= 0 && expBin == abortAt) begin
                hist_ready = 1'b0;
                pulseReset();
                return;
            end
            if (inject == expBin && hist_valid) begin
                lbp_valid = 1'b1;
                lbp_data = 8'd7;
                lbp_addr = 14'd200;
                inject = -1;
            end
            if (hist_valid) checkOutput("dumpOrder", int'(hist_bin), expBin);
            if (hist_valid && hist_ready) begin
                dumpCnt[expBin & 255] = int'(hist_count);
                expBin++;
                lastAccept = cycles;
            end
            if (hist_done) doneCycle = cycles;
            tick();
            cycles++;
        end
        lbp_valid = 1'b0;
        hist_ready = 1'b0;
        checkOutput("binsAccepted", expBin, 256);
        checkOutput("doneGap", doneCycle - lastAccept, 1);
    endtask

    function automatic int dumpSum();
        int s = 0;
        foreach (dumpCnt[i]) s += dumpCnt[i];
        return s;
    endfunction

    function automatic int dumpNonZero();
        int n = 0;
        foreach (dumpCnt[i]) if (dumpCnt[i] != 0) n++;
        return n;
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int addr;
        pulseReset();

        // Reset values.
        checkOutput("rst_valid", int'(hist_valid), 0);
        checkOutput("rst_bin", int'(hist_bin), 0);
        checkOutput("rst_count", int'(hist_count), 0);
        checkOutput("rst_done", int'(hist_done), 0);
        checkOutput("rst_total", int'(pix_total), 0);
        checkOutput("rst_err", int'(err), 0);

        // Three interior samples, then a plain dump.
        applyStimulus(1, 8'h05, 129, 0);
        applyStimulus(1, 8'h05, 130, 0);
        applyStimulus(1, 8'hFF, 131, 0);
        checkOutput("t1_total", int'(pix_total), 3);
        checkOutput("t1_modelBin5", mBins[5], 2);
        applyStimulus(0, 0, 0, 1);
        doDump(0, -1, -1);
        checkOutput("t1_bin5", dumpCnt[5], 2);
        checkOutput("t1_bin255", dumpCnt[255], 1);
        checkOutput("t1_nonzero", dumpNonZero(), 2);
        checkOutput("t1_err", int'(err), 0);

        // Two full interior frames with code = addr[7:0].
        for (int f = 0; f < 2; f++) begin
            for (int row = 1; row <= 126; row++) begin
                for (int col = 1; col <= 126; col++) begin
                    addr = row * 128 + col;
                    applyStimulus(1, addr & 255, addr, 0);
                end
            end
            checkOutput("frame_total", int'(pix_total), 15876);
            applyStimulus(0, 0, 0, 1);
            doDump(0, -1, -1);
            checkOutput("frame_sum", dumpSum(), 15876);
            for (int b = 0; b < 256; b++) begin
                checkOutput("frame_bin", dumpCnt[b],
                            ((b >= 1 && b <= 126) || (b >= 129 && b <= 254)) ? 63 : 0);
            end
            checkOutput("frame_err", int'(err), 0);
        end

        // Backpressure with pseudo-random ready.
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1, (i * 7) & 255, 2 * 128 + 1 + i, 0);
        end
        applyStimulus(0, 0, 0, 1);
        doDump(1, -1, -1);
        for (int i = 0; i < 40; i++) begin
            checkOutput("bp_bin", dumpCnt[(i * 7) & 255], 1);
        end
        checkOutput("bp_sum", dumpSum(), 40);

        // Border sample counted with err; sample during dump dropped with err.
        applyStimulus(1, 3, 0, 0);
        checkOutput("err_border", int'(err), 1);
        applyStimulus(0, 0, 0, 1);
        doDump(0, -1, 10);
        checkOutput("err_bin3", dumpCnt[3], 1);
        checkOutput("err_bin7", dumpCnt[7], 0);
        tick();
        tick();
        checkOutput("err_sticky", int'(err), 1);
        pulseReset();
        checkOutput("err_cleared", int'(err), 0);

        // Valid and finish in the same cycle.
        applyStimulus(1, 8'h10, 300, 1);
        doDump(0, -1, -1);
        checkOutput("same_bin16", dumpCnt[16], 1);
        checkOutput("same_sum", dumpSum(), 1);

        // Reset in the middle of a dump, then a one-sample frame.
        for (int i = 0; i < 20; i++) applyStimulus(1, 120, 2 * 128 + 1 + i, 0);
        for (int i = 0; i < 20; i++) applyStimulus(1, 200, 3 * 128 + 1 + i, 0);
        applyStimulus(0, 0, 0, 1);
        doDump(0, 100, -1);
        checkOutput("abort_valid", int'(hist_valid), 0);
        checkOutput("abort_total", int'(pix_total), 0);
        applyStimulus(1, 8'h42, 1000, 0);
        applyStimulus(0, 0, 0, 1);
        doDump(0, -1, -1);
        checkOutput("abort_nonzero", dumpNonZero(), 1);
        checkOutput("abort_bin42", dumpCnt[8'h42], 1);

        tick();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/lbp_hist.md
# lbp_hist

Histogram stage directly downstream of the LBP engine. It consumes the LBP result stream (`lbp_valid`/`lbp_data`/`lbp_addr`/`finish`) and counts the occurrences of each of the 256 LBP codes over one 128x128 frame. On `finish` it streams the 256 bin counts to the feature consumer through a valid/ready handshake. Each bin is cleared as it is read, so the block is ready for the next frame without a separate clear pass.

## Interface
- `COUNT_W`, 14: width of each bin counter and of the sample total. Covers 126*126 = 15876 interior pixels.
- `IMG_W`, 128: image line width; used only for the border check.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `lbp_valid`  in  1  one LBP result present this cycle.
- `lbp_data`  in  8  LBP code, used as the bin index.
- `lbp_addr`  in  14  pixel address of the result.
- `finish`  in  1  frame complete; level, may stay high several cycles.
- `hist_ready`  in  1  consumer accepts the current bin.
- `hist_valid`  out  1  bin output valid.
- `hist_bin`  out  8  bin index being presented.
- `hist_count`  out  COUNT_W  count for `hist_bin`.
- `hist_done`  out  1  one-cycle pulse after bin 255 is accepted.
- `pix_total`  out  COUNT_W  number of samples accumulated this frame.
- `err`  out  1  sticky error flag; cleared only by `reset`.

## Operation
- States: ACCUM, DUMP, DONE. Reset state is ACCUM.
- Reset values:
  - all 256 bins = 0, `pix_total` = 0
  - `hist_valid` = 0, `hist_bin` = 0, `hist_count` = 0, `hist_done` = 0, `err` = 0
- ACCUM, on `lbp_valid`=1:
  - `bins[lbp_data]` += 1 and `pix_total` += 1.
  - Both saturate at 2^COUNT_W-1. Any saturation event sets `err`.
- Border check: a valid sample whose `lbp_addr` is on the border is still counted and sets `err`.
  - Border means `addr[6:0]` is 0 or 127, or `addr` < 128, or `addr` >= 16256.
- ACCUM -> DUMP when `finish`=1.
  - If `lbp_valid` and `finish` are both high in the same cycle, that sample is counted first.
  - The bin index `idx` is set to 0.
- DUMP:
  - `hist_valid`=1, `hist_bin`=`idx`, `hist_count`=`bins[idx]`.
  - On `hist_valid & hist_ready`, `bins[idx]` <= 0 and `idx` += 1.
  - While `hist_ready`=0, all outputs hold stable.
  - Accepting `idx`=255 moves the block to DONE.
- Samples arriving during DUMP or DONE (`lbp_valid`=1) are dropped: no bin is updated and `err` is set.
- `finish` has no effect outside ACCUM.
- DONE lasts exactly one cycle:
  - `hist_done`=1, `hist_valid`=0, `pix_total` <= 0.
  - Next state is ACCUM, regardless of `finish`.
  - A `finish` still held high when ACCUM is re-entered starts a new DUMP. The upstream LBP engine deasserts `finish` on its own return to idle.
- Bins are a register array with a single read-modify-write per cycle. Back-to-back valids to the same code are counted correctly, with no stall.

## Timing
- A sample in cycle N appears in the bin and in `pix_total` from cycle N+1.
- `finish` sampled high at edge N: `hist_valid`=1 for bin 0 from N+1.
- Full dump with `hist_ready` held at 1: 256 cycles, then one DONE cycle, then ACCUM. `finish` to the next ACCUM takes 258 cycles.
- `hist_valid`, `hist_bin` and `hist_done` are decoded from registered state and index only; there is no combinational path from `hist_ready`.
- Reset asserted mid-DUMP: the block returns immediately to ACCUM with all bins 0. The partial dump is abandoned.

## Test plan
- Reset, then 3 samples with codes 0x05, 0x05, 0xFF at interior addresses 129, 130, 131, then `finish` with `hist_ready`=1:
  - bin 5 = 2, bin 255 = 1, all other bins 0.
  - `pix_total` = 3 before dump.
  - `hist_done` pulses one cycle after bin 255 is accepted.
  - `err` = 0.
- Full frame: 15876 interior samples with code = addr[7:0], then dump:
  - the sum of `hist_count` over all bins = 15876 and equals `pix_total`.
  - A second frame afterwards produces an identical dump, proving the clear-on-read.
- Backpressure: toggle `hist_ready` pseudo-randomly during the dump.
  - Every bin appears exactly once, in order 0..255.
  - `hist_bin`/`hist_count` stay stable while `hist_ready`=0.
- Sample with `lbp_addr` = 0, and a sample during DUMP:
  - the first is counted and sets `err`.
  - the second is dropped and sets `err`.
  - `err` stays 1 until reset.
- `lbp_valid` and `finish` high in the same cycle with code 0x10: bin 16 includes that sample in the dump.
- Reset asserted at bin 100 of a dump, then a fresh 1-sample frame: the dump shows exactly one nonzero bin, with count 1.
